wb_unit: RTL and testbench



---
 rtl/wb_unit.sv | 207 ++++++++++++++++++++
 tb/tb_wb_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// wb_unit: write-back stage of the minimal MIPS core.
// Takes retiring instructions from EX/MEM and picks the destination register
// and write data. It drives one registered write strobe into the ID-stage
// register file.
// Loads park the unit in WAIT_MEM until the load data returns. A timer aborts
// a load whose data never arrives and raises a one-cycle error pulse.
//
// Handshake (valid/ready): a transfer happens on a rising CLK edge where
// in_valid && in_ready. in_ins/in_alu/in_pc are sampled only at a transfer.
// in_ready depends only on internal state (high exactly in IDLE), never on
// in_valid. Upstream must hold its payload stable until the transfer.
`timescale 1ns/1ps

module wb_unit #(
    parameter int MEM_TIMEOUT = 16,  // max cycles spent in WAIT_MEM, must be >= 1
    parameter int CNT_W       = 16   // width of the retired-write counter
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ins,
    input  logic [31:0]      in_alu,
    input  logic [31:0]      in_pc,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             wb_busy,
    output logic             wb_err,
    output logic [CNT_W-1:0] wb_count
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    // The timer only has to reach MEM_TIMEOUT-1, so it never needs more bits than that.
    localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RFORM = 6'd0;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [4:0] REG_RA   = 5'd31;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    logic [0:0]       state_q,    state_d;
    logic [TMR_W-1:0] timer_q,    timer_d;
    logic [4:0]       ld_dest_q,  ld_dest_d;
    logic             we_q,       we_d;
    logic [4:0]       waddr_q,    waddr_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic             err_q,      err_d;
    logic [CNT_W-1:0] count_q,    count_d;

    // ------------------------------------------------------------------
    // Decode signals
    // ------------------------------------------------------------------
    logic [5:0]  dec_op;
    logic [5:0]  dec_funct;
    logic        dec_write;   // non-load instruction that writes a register
    logic        dec_load;    // LW: data comes later from memory
    logic [4:0]  dec_dest;
    logic [31:0] dec_data;
    logic        xfer;

    assign dec_op    = in_ins[31:26];
    assign dec_funct = in_ins[5:0];
    assign xfer      = in_valid && in_ready;

    // Decode destination register and write-data source for the offered instruction
    always_comb begin
        dec_write = 1'b0;
        dec_load  = 1'b0;
        dec_dest  = 5'd0;
        dec_data  = 32'd0;
        // An all-zero word is the canonical NOP and never writes.
        if (in_ins != 32'd0) begin
            case (dec_op)
                OP_RFORM: begin
                    // funct 0 with a nonzero word is a shift form that this
                    // core does not retire through write-back.
                    if (dec_funct != 6'd0) begin
                        dec_write = 1'b1;
                        dec_dest  = in_ins[15:11];
                        dec_data  = in_alu;
                    end
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                    dec_write = 1'b1;
                    dec_dest  = in_ins[20:16];
                    dec_data  = in_alu;
                end
                OP_JAL: begin
                    // Link address skips the branch delay slot.
                    dec_write = 1'b1;
                    dec_dest  = REG_RA;
                    dec_data  = in_pc + 32'd8;
                end
                OP_LW: begin
                    dec_load  = 1'b1;
                    dec_dest  = in_ins[20:16];
                end
                default: begin
                    dec_write = 1'b0;
                end
            endcase
        end
    end

    // Next-state, timer and write-strobe logic for the IDLE/WAIT_MEM machine
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ld_dest_d = ld_dest_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // mem_rvalid is ignored here: no load is outstanding.
                if (xfer) begin
                    if (dec_load) begin
                        state_d   = WAIT_MEM;
                        ld_dest_d = dec_dest;
                        timer_d   = '0;
                    end else if (dec_write && (dec_dest != 5'd0)) begin
                        we_d    = 1'b1;
                        waddr_d = dec_dest;
                        wdata_d = dec_data;
                    end
                end
            end
            WAIT_MEM: begin
                // Returning data takes priority over a timeout in the same cycle.
                if (mem_rvalid) begin
                    state_d = IDLE;
                    // A load to $0 still waits for its data, which is then dropped.
                    if (ld_dest_q != 5'd0) begin
                        we_d    = 1'b1;
                        waddr_d = ld_dest_q;
                        wdata_d = mem_rdata;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The retired-write counter advances together with every strobe it counts and wraps naturally
    always_comb begin
        count_d = count_q + CNT_W'(we_d);
    end

    // Register state and outputs; synchronous reset drops any pending load
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            ld_dest_q <= 5'd0;
            we_q      <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= 32'd0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ld_dest_q <= ld_dest_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            count_q   <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: everything visible is registered or a pure state decode
    // ------------------------------------------------------------------
    assign in_ready = (state_q == IDLE);
    assign wb_busy  = (state_q == WAIT_MEM);
    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign wb_err   = err_q;
    assign wb_count = count_q;

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: bench for the write-back stage.
// Drivers push each expected register write or error pulse into a queue,
// stamped with the cycle in which it must appear. A negedge monitor pops
// those entries and compares them against the outputs.
`timescale 1ns/1ps

module tb_wb_unit;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 16;

    // ---------------- clock / reset ----------------
    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_ins = 32'd0;
    logic [31:0]      in_alu = 32'd0;
    logic [31:0]      in_pc  = 32'd0;
    logic             mem_rvalid = 1'b0;
    logic [31:0]      mem_rdata  = 32'd0;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             wb_busy;
    logic             wb_err;
    logic [CNT_W-1:0] wb_count;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    // Expected writes: {due cycle[31:0], addr[4:0], data[31:0]}
    logic [68:0]      exp_q[$];
    logic [31:0]      err_q[$];
    logic [68:0]      mon_e;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [4:0]       last_a  = 5'd0;
    logic [31:0]      last_d  = 32'd0;
    logic [5:0]       other_ops [0:5] = '{6'd2, 6'd4, 6'd5, 6'd43, 6'd15, 6'd13};

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    wb_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ins(in_ins), .in_alu(in_alu), .in_pc(in_pc),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_busy(wb_busy), .wb_err(wb_err), .wb_count(wb_count)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: instruction rules in plain arithmetic.
    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] alu,
                                       input logic [31:0] pc, output bit wr, output bit ld,
                                       output logic [4:0] dst, output logic [31:0] dat);
        int op;
        int funct;
        op    = int'(ins >> 26);
        funct = int'(ins & 32'h3f);
        wr = 1'b0; ld = 1'b0; dst = 5'd0; dat = 32'd0;
        if (ins == 32'd0) return;
        if (op == 0 && funct != 0) begin
            wr = 1'b1; dst = 5'((ins >> 11) & 32'h1f); dat = alu;
        end else if (op >= 8 && op <= 11) begin
            wr = 1'b1; dst = 5'((ins >> 16) & 32'h1f); dat = alu;
        end else if (op == 3) begin
            wr = 1'b1; dst = 5'd31; dat = pc + 32'd8;
        end else if (op == 35) begin
            ld = 1'b1; dst = 5'((ins >> 16) & 32'h1f);
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Offer one instruction while the unit is idle; it transfers at the next edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] pc);
        bit          wr;
        bit          ld;
        logic [4:0]  dst;
        logic [31:0] dat;
        @(negedge CLK);
        in_valid = 1'b1; in_ins = ins; in_alu = alu; in_pc = pc;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        ref_decode(ins, alu, pc, wr, ld, dst, dat);
        if (wr && dst != 5'd0) exp_q.push_back({32'(cyc + 1), dst, dat});
        @(posedge CLK);
        #1;
        in_valid = 1'b0; in_ins = $urandom; in_alu = $urandom; in_pc = $urandom;
    endtask

    // Load to rt. Data returns 'delay' cycles into the wait; delay >= MEM_TIMEOUT means never.
    // hold: a follower ADDI-class instruction is held valid through the whole wait.
    // late: a stray mem_rvalid is sent once the unit is idle again.
    task automatic lw_op(input logic [4:0] rt, input int delay, input logic [31:0] rdata,
                         input bit hold, input bit late);
        logic [31:0] fol;
        logic [31:0] fol_alu;
        bit          wr;
        bit          ld;
        logic [4:0]  dst;
        logic [31:0] dat;
        send({6'd35, 5'($urandom), rt, 16'($urandom)}, $urandom, $urandom);
        fol     = {6'(8 + $urandom_range(0, 3)), 5'($urandom), 5'($urandom), 16'($urandom)};
        fol_alu = $urandom;
        if (hold) begin
            in_valid = 1'b1; in_ins = fol; in_alu = fol_alu; in_pc = 32'h0;
        end
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            @(negedge CLK);
            check("wait_busy", 32'(wb_busy), 32'd1);
            check("wait_in_ready", 32'(in_ready), 32'd0);
            if (delay < MEM_TIMEOUT && k == delay) begin
                mem_rvalid = 1'b1; mem_rdata = rdata;
                if (rt != 5'd0) exp_q.push_back({32'(cyc + 1), rt, rdata});
                @(posedge CLK);
                #1;
                mem_rvalid = 1'b0; mem_rdata = $urandom;
                break;
            end
            if (k == MEM_TIMEOUT - 1) begin
                err_q.push_back(32'(cyc + 1));
                @(posedge CLK);
                #1;
            end
        end
        // The write or the error pulse is visible in this cycle; the unit is idle again.
        @(negedge CLK);
        check("after_wait_ready", 32'(in_ready), 32'd1);
        check("after_wait_busy", 32'(wb_busy), 32'd0);
        if (late) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
        end
        if (hold) begin
            ref_decode(fol, fol_alu, 32'h0, wr, ld, dst, dat);
            if (wr && dst != 5'd0) exp_q.push_back({32'(cyc + 1), dst, dat});
        end
        if (late || hold) begin
            @(posedge CLK);
            #1;
            mem_rvalid = 1'b0; in_valid = 1'b0;
        end
    endtask

    // Synchronous reset for one cycle, optionally with a coincident mem_rvalid.
    task automatic do_reset(input bit with_rvalid);
        @(negedge CLK);
        RST = 1'b1; in_valid = 1'b0;
        mem_rvalid = with_rvalid; mem_rdata = $urandom;
        exp_q.delete(); err_q.delete();
        exp_cnt = '0; last_a = 5'd0; last_d = 32'd0;
        @(negedge CLK);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_wb_err", 32'(wb_err), 32'd0);
        check("rst_wb_count", 32'(wb_count), 32'd0);
        check("rst_wb_busy", 32'(wb_busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        RST = 1'b0; mem_rvalid = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        if (!RST) begin
            while (exp_q.size() > 0 && int'(exp_q[0][68:37]) < cyc) begin
                total++; bad++;
                $display("FAIL write_missing: rf_we stayed 0, required addr %0d data 0x%0h at cycle %0d",
                         exp_q[0][36:32], exp_q[0][31:0], exp_q[0][68:37]);
                void'(exp_q.pop_front());
            end
            while (err_q.size() > 0 && int'(err_q[0]) < cyc) begin
                total++; bad++;
                $display("FAIL err_missing: wb_err stayed 0, required a pulse at cycle %0d", err_q[0]);
                void'(err_q.pop_front());
            end
            if (rf_we) begin
                if (exp_q.size() > 0 && int'(exp_q[0][68:37]) == cyc) begin
                    mon_e = exp_q.pop_front();
                    check("rf_waddr", 32'(rf_waddr), 32'(mon_e[36:32]));
                    check("rf_wdata", rf_wdata, mon_e[31:0]);
                    exp_cnt = exp_cnt + 1'b1;
                    last_a  = mon_e[36:32];
                    last_d  = mon_e[31:0];
                end else begin
                    total++; bad++;
                    $display("FAIL unexpected_write: rf_we=1 addr %0d data 0x%0h, required rf_we=0 (cycle %0d)",
                             rf_waddr, rf_wdata, cyc);
                    last_a = rf_waddr;
                    last_d = rf_wdata;
                end
            end else begin
                check("hold_waddr", 32'(rf_waddr), 32'(last_a));
                check("hold_wdata", rf_wdata, last_d);
            end
            check("wb_count", 32'(wb_count), 32'(exp_cnt));
            if (wb_err) begin
                if (err_q.size() > 0 && int'(err_q[0]) == cyc) begin
                    total++;
                    void'(err_q.pop_front());
                end else begin
                    total++; bad++;
                    $display("FAIL unexpected_err: wb_err=1, required 0 (cycle %0d)", cyc);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge CLK);
        do_reset(1'b0);

        // ADD $3 = 5: written the cycle after transfer, count becomes 1.
        send(32'h00221820, 32'h5, 32'h0);
        @(negedge CLK);
        check("add_we", 32'(rf_we), 32'd1);
        check("add_waddr", 32'(rf_waddr), 32'd3);
        check("add_wdata", rf_wdata, 32'd5);
        check("add_count", 32'(wb_count), 32'd1);

        // ADDI to $0 and a zero word: no writes, count unchanged.
        send(32'h20000007, 32'h7, 32'h0);
        send(32'h00000000, 32'h9, 32'h0);
        repeat (2) @(negedge CLK);
        check("nop_we", 32'(rf_we), 32'd0);
        check("nop_count", 32'(wb_count), 32'd1);

        // JAL: link into $31.
        send(32'h0C100004, $urandom, 32'h00400010);
        @(negedge CLK);
        check("jal_waddr", 32'(rf_waddr), 32'd31);
        check("jal_wdata", rf_wdata, 32'h00400018);

        // LW $8, data after 3 wait cycles, with a held ADDI behind it.
        lw_op(5'd8, 3, 32'hDEADBEEF, 1'b1, 1'b0);
        // LW that times out, followed by a stray late mem_rvalid.
        lw_op(5'd5, MEM_TIMEOUT, 32'h0, 1'b0, 1'b1);
        // LW to $0 still waits; the data is dropped.
        lw_op(5'd0, 2, 32'h12345678, 1'b0, 1'b0);

        // Reset in the middle of a load, coincident with mem_rvalid.
        send({6'd35, 5'd1, 5'd9, 16'h0010}, 32'h0, 32'h0);
        repeat (2) @(negedge CLK);
        check("midload_busy", 32'(wb_busy), 32'd1);
        do_reset(1'b1);

        // Randomized mix, back-to-back and with gaps.
        for (int i = 0; i < 80; i++) begin
            int kind;
            kind = $urandom_range(0, 5);
            case (kind)
                0: send({6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                         ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63))},
                        $urandom, $urandom);
                1: send({6'(8 + $urandom_range(0, 3)), 5'($urandom), 5'($urandom), 16'($urandom)},
                        $urandom, $urandom);
                2: send({6'd3, 26'($urandom)}, $urandom, $urandom);
                3: send({other_ops[$urandom_range(0, 5)], 5'($urandom), 5'($urandom), 16'($urandom)},
                        $urandom, $urandom);
                4: send(32'd0, $urandom, $urandom);
                default: lw_op(5'($urandom), $urandom_range(0, MEM_TIMEOUT + 2), $urandom,
                               1'($urandom), 1'($urandom));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        repeat (3) @(negedge CLK);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("err_q_drained", 32'(err_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
